// File: rtl/rocketcpu_pkg.sv
// ============================================================================
// rocketcpu_pkg : shared constants for the RocketCPU bus arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package rocketcpu_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_I = 2'd1;
  localparam logic [1:0] ST_GNT_D = 2'd2;

  localparam logic M_IBUS = 1'b0;
  localparam logic M_DBUS = 1'b1;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/rocketcpu_bus_timeout.sv
// ============================================================================
// rocketcpu_bus_timeout : grant-cycle watchdog counter, expires at TIMEOUT-1
// Rev 1.0
// ============================================================================
`default_nettype none

module rocketcpu_bus_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_disabled
      logic w_unused;
      assign w_unused = ^{clk, rst, clr, en};
      assign expire   = 1'b0;
    end else begin : g_counter
      localparam int W = $clog2(TIMEOUT) + 1;
      localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

      logic [W-1:0] r_cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (clr) begin
          r_cnt <= '0;
        end else if (en) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign expire = en && (r_cnt == LIMIT);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/rocketcpu_bus_arbiter.sv
// ============================================================================
// rocketcpu_bus_arbiter : registered round-robin ibus/dbus Wishbone arbiter
// with a bus-timeout watchdog and sticky error capture.  Rev 1.0
// ============================================================================
`default_nettype none

module rocketcpu_bus_arbiter
  import rocketcpu_pkg::*;
#(
  parameter int          TIMEOUT   = 64,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input  logic        i_wb_clk,
  input  logic        i_rst,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic [31:0] o_mem_adr,
  output logic [31:0] o_mem_dat,
  output logic [3:0]  o_mem_sel,
  output logic        o_mem_we,
  output logic        o_mem_cyc,
  input  logic [31:0] i_mem_rdt,
  input  logic        i_mem_ack,
  output logic        o_err,
  output logic [31:0] o_err_adr,
  input  logic        i_err_clr
);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_last;
  logic        w_last_nxt;
  logic        r_err;
  logic [31:0] r_err_adr;

  logic        w_gnt_i;
  logic        w_gnt_d;
  logic        w_gnt;
  logic        w_cyc;
  logic        w_expire;
  logic        w_timeout;
  logic [31:0] w_adr;

  assign w_gnt_i = (r_state == ST_GNT_I);
  assign w_gnt_d = (r_state == ST_GNT_D);
  assign w_gnt   = w_gnt_i | w_gnt_d;

  assign w_cyc = w_gnt_i ? i_ibus_cyc : (w_gnt_d ? i_dbus_cyc : 1'b0);
  assign w_adr = w_gnt_i ? i_ibus_adr : (w_gnt_d ? i_dbus_adr : 32'h0);

  rocketcpu_bus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (i_wb_clk),
    .rst    (i_rst),
    .clr    (~w_gnt),
    .en     (w_gnt),
    .expire (w_expire)
  );

  // A same-cycle slave ack always beats the watchdog.
  assign w_timeout = w_expire & w_cyc & ~i_mem_ack;

  assign o_mem_cyc = w_cyc & ~w_timeout;
  assign o_mem_adr = w_adr;
  assign o_mem_dat = w_gnt_d ? i_dbus_dat : 32'h0;
  assign o_mem_sel = w_gnt_i ? 4'hF : (w_gnt_d ? i_dbus_sel : 4'h0);
  assign o_mem_we  = w_gnt_d & i_dbus_we;

  assign o_ibus_ack = w_gnt_i & (i_mem_ack | w_timeout);
  assign o_dbus_ack = w_gnt_d & (i_mem_ack | w_timeout);
  assign o_ibus_rdt = !w_gnt_i ? 32'h0 : (w_timeout ? ERR_RDATA : i_mem_rdt);
  assign o_dbus_rdt = !w_gnt_d ? 32'h0 : (w_timeout ? ERR_RDATA : i_mem_rdt);

  assign o_err     = r_err;
  assign o_err_adr = r_err_adr;

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (i_ibus_cyc && (!i_dbus_cyc || r_last == M_DBUS)) begin
          w_state_nxt = ST_GNT_I;
        end else if (i_dbus_cyc) begin
          w_state_nxt = ST_GNT_D;
        end
      end
      ST_GNT_I, ST_GNT_D: begin
        if (i_mem_ack || w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = w_gnt_i ? M_IBUS : M_DBUS;
        end else if (!w_cyc) begin
          // Master abandoned the request; fairness history is untouched.
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_wb_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_last  <= M_DBUS;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // A timeout in the same cycle as a clear re-arms with the new address.
  always_ff @(posedge i_wb_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err     <= 1'b0;
      r_err_adr <= 32'h0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
      if (!r_err || i_err_clr) begin
        r_err_adr <= w_adr;
      end
    end else if (i_err_clr) begin
      r_err     <= 1'b0;
      r_err_adr <= 32'h0;
    end
  end

endmodule

`default_nettype wire

// File: doc/rocketcpu_bus_arbiter.md
# rocketcpu_bus_arbiter

Registered two-master Wishbone arbiter with bus-timeout watchdog. It shares the single memory bus between the SERV instruction bus (read-only) and data bus. It replaces the combinational ibus/dbus arbiter ahead of the address decoder that feeds flash, RAM, UART, GPIO, timer, IRQ, audio and codec-SPI slaves. A hung or unmapped access is aborted after a bounded number of cycles instead of stalling the CPU forever.

## Interface
Parameters:
- TIMEOUT, 64: grant cycles without slave ack before abort; 0 disables the watchdog.
- ERR_RDATA, 32'hFFFF_FFFF: read data returned on an aborted access.

Ports:
- i_wb_clk  in  1  system clock (12 MHz).
- i_rst  in  1  reset; asynchronous, active-high.
- i_ibus_adr  in  32  instruction fetch address.
- i_ibus_cyc  in  1  fetch request.
- o_ibus_rdt  out  32  fetch data.
- o_ibus_ack  out  1  fetch complete.
- i_dbus_adr / i_dbus_dat  in  32  data address / write data.
- i_dbus_sel  in  4  byte enables.
- i_dbus_we  in  1  write enable.
- i_dbus_cyc  in  1  data request.
- o_dbus_rdt  out  32  read data.
- o_dbus_ack  out  1  data complete.
- o_mem_adr / o_mem_dat  out  32  address / write data to decoder.
- o_mem_sel  out  4  byte enables.
- o_mem_we  out  1  write enable.
- o_mem_cyc  out  1  bus cycle.
- i_mem_rdt  in  32  slave read data.
- i_mem_ack  in  1  slave ack.
- o_err  out  1  sticky timeout flag.
- o_err_adr  out  32  address of the first timed-out access.
- i_err_clr  in  1  clears o_err and o_err_adr.

## Operation
- FSM states: IDLE, GNT_I, GNT_D. Register `last` holds the most recent grantee (I/D).
- IDLE: only ibus requesting goes to GNT_I. Only dbus requesting goes to GNT_D. Both requesting: the master not equal to `last` wins (round-robin). Neither requesting: stay in IDLE.
- GNT_x: mem adr/dat/sel/we come from master x; ibus drives we=0, sel=4'hF, dat=0. o_mem_cyc = i_x_cyc.
- In GNT_x: i_mem_ack passes to o_x_ack and i_mem_rdt to o_x_rdt. The other master's ack is 0; its rdt is 0.
- Slave ack: next state is IDLE, and `last` is set to x.
- Master x drops cyc before ack: abandon, go to IDLE, `last` is unchanged.
- Watchdog: counter cleared on entry to GNT_x, increments each grant cycle. At count == TIMEOUT-1 with no ack:
  - force o_mem_cyc=0;
  - assert o_x_ack=1 with o_x_rdt=ERR_RDATA;
  - set o_err; if o_err was 0, capture the address into o_err_adr;
  - next state is IDLE, `last` is set to x.
- Ack and timeout in the same cycle: ack wins, and no error is recorded.
- i_err_clr clears o_err and o_err_adr. If clear coincides with a new timeout, the set wins.
- IDLE outputs: all o_mem_* are 0; both master acks are 0.

## Timing
- Reset values: state IDLE; `last`=D, so ibus wins the first tie; counter 0; o_err 0; o_err_adr 0; all outputs 0.
- Grant latency: a request seen at edge N makes o_mem_cyc high in cycle N+1.
- Ack is combinational from slave to master; no extra latency.
- Minimum transaction is 2 cycles: grant, then ack. One IDLE cycle always separates two grants.
- Maximum stall per access is TIMEOUT cycles, plus 1 for arbitration.
- Reset mid-grant: state returns to IDLE asynchronously, and o_mem_cyc drops immediately.

## Structure
- Shared package rocketcpu_pkg holds:
  - state encoding localparams ST_IDLE/ST_GNT_I/ST_GNT_D;
  - the master index constants M_IBUS/M_DBUS;
  - the default ERR_RDATA.
- One sub-module, rocketcpu_bus_timeout: a parameterised counter with clear/enable inputs and an expire output. Width is $clog2(TIMEOUT)+1; TIMEOUT=0 ties expire low.
- Everything else is flat in rocketcpu_bus_arbiter.

## Test plan
- Ibus-only fetch, address 0x0010_0000, slave ack on the 2nd grant cycle with rdt 0x1234_5678 → o_mem_cyc high from cycle N+1; o_ibus_ack with 0x1234_5678; o_dbus_ack stays 0.
- Simultaneous ibus and dbus requests after reset → ibus granted first. After its ack: one IDLE cycle, then dbus granted with we/sel/dat passed through. Next tie goes to ibus again.
- Dbus write to 0x0200_0000 (dat 0x1, sel 4'h1, we=1) with same-cycle ack → GPIO sees exactly one cycle with we=1, dat=0x1.
- Dbus read of unmapped 0x0300_0000, ack never given, TIMEOUT=64:
  - o_dbus_ack in grant cycle 64 with rdt 0xFFFF_FFFF;
  - o_mem_cyc low that cycle;
  - o_err=1, o_err_adr=0x0300_0000.
- Second timeout at 0x0500_0000 while o_err=1 → o_err_adr keeps 0x0300_0000. i_err_clr pulse → both clear. Clear coinciding with a timeout → o_err=1 with the new address.
- Assert i_rst mid-grant → o_mem_cyc drops before the next edge; after release, state is IDLE, o_err=0, and the first tie goes to ibus.
